// File: rtl/led_fader_pkg.sv
// Shared constants for the LED colour fader: register offsets, CTRL/STATUS bit positions.
// Latency: n/a (constants only).
// Backpressure: n/a.
package led_fader_pkg;

  localparam int PRESCALE_W = 16;

  // Word offsets; CURRENT[c] follows the TARGET block at OFF_TARGET + NUM_CH + c
  localparam int OFF_CTRL     = 0;
  localparam int OFF_STATUS   = 1;
  localparam int OFF_PRESCALE = 2;
  localparam int OFF_STEP     = 3;
  localparam int OFF_TARGET   = 4;

  localparam int CTRL_EN_BIT       = 0;
  localparam int CTRL_SNAP_BIT     = 1;
  localparam int CTRL_IRQ_MASK_LSB = 16;

  localparam int STATUS_BUSY_LSB = 0;
  localparam int STATUS_DONE_LSB = 16;

  // Word offset of the read-only CURRENT register of channel c
  function automatic int current_offset(input int num_ch, input int c);
    return OFF_TARGET + num_ch + c;
  endfunction

endpackage

// File: rtl/led_fade_channel.sv
// One RGB channel: current colour ramps toward target on each tick, BUSY and DONE-set edge detect.
// Latency: current updates on the edge of the tick/snap cycle; done_set is high the cycle after BUSY drops.
// Backpressure: none; tick and snap are single-cycle strobes consumed every cycle.
module led_fade_channel
  import led_fader_pkg::*;
#(
  parameter int CH_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              tick,
  input  logic              snap,
  input  logic [3*CH_W-1:0] target,
  input  logic [CH_W-1:0]   step,
  output logic [3*CH_W-1:0] current,
  output logic              busy,
  output logic              done_set
);

  logic [3*CH_W-1:0] cur_next;
  logic              busy_q;

  // Move one component toward its target by min(step, |diff|); step 0 jumps straight there
  function automatic logic [CH_W-1:0] step_toward(input logic [CH_W-1:0] cur,
                                                  input logic [CH_W-1:0] tgt,
                                                  input logic [CH_W-1:0] stp);
    logic [CH_W:0] diff;
    logic [CH_W:0] mv;
    if (tgt >= cur) diff = {1'b0, tgt} - {1'b0, cur};
    else            diff = {1'b0, cur} - {1'b0, tgt};
    if (stp == '0 || {1'b0, stp} >= diff) mv = diff;
    else                                  mv = {1'b0, stp};
    if (tgt >= cur) return cur + mv[CH_W-1:0];
    else            return cur - mv[CH_W-1:0];
  endfunction

  // Next colour if a tick lands this cycle, each component independent
  always_comb begin
    cur_next = current;
    for (int i = 0; i < 3; i++) begin
      cur_next[i*CH_W +: CH_W] = step_toward(current[i*CH_W +: CH_W],
                                             target[i*CH_W +: CH_W], step);
    end
  end

  assign busy     = (current != target);
  assign done_set = busy_q & ~busy;

  // Colour register (snap has priority over tick) and registered BUSY for completion detect
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      current <= '0;
      busy_q  <= 1'b0;
    end else begin
      busy_q <= busy;
      if (snap)      current <= target;
      else if (tick) current <= cur_next;
    end
  end

endmodule

// File: rtl/led_color_fader.sv
// Avalon-MM multi-channel RGB fader: registers, prescaler, read mux, fade-done irq.
// Latency: writes land on the write-cycle edge, readdata is combinational, irq one cycle after DONE&MASK.
// Backpressure: none; every slave access completes in one cycle. LED_FADER_IRQ_EN enables IRQ_MASK and irq.
module led_color_fader
  import led_fader_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 8,
  parameter int ADDR_W = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [ADDR_W-1:0]        address,
  input  logic                     chipselect,
  input  logic                     write_n,
  input  logic [31:0]              writedata,
  output logic [31:0]              readdata,
  output logic [NUM_CH*3*CH_W-1:0] out_port,
  output logic                     irq
);

  localparam int COL_W = 3 * CH_W;

  logic                  wr_en;
  logic                  snap;
  logic                  tick;
  logic                  en_q;
  logic [PRESCALE_W-1:0] prescale_q;
  logic [PRESCALE_W-1:0] presc_cnt;
  logic [CH_W-1:0]       step_q;
  logic [COL_W-1:0]      target_q [NUM_CH];
  logic [COL_W-1:0]      cur      [NUM_CH];
  logic [NUM_CH-1:0]     busy;
  logic [NUM_CH-1:0]     done_set;
  logic [NUM_CH-1:0]     done_q;
  logic [NUM_CH-1:0]     done_w1c;
  logic [NUM_CH-1:0]     irq_mask;
  logic                  unused_wdata;

  assign wr_en        = chipselect & ~write_n;
  assign snap         = wr_en && (address == ADDR_W'(OFF_CTRL)) && writedata[CTRL_SNAP_BIT];
  assign done_w1c     = (wr_en && (address == ADDR_W'(OFF_STATUS)))
                        ? writedata[STATUS_DONE_LSB +: NUM_CH] : '0;
  assign tick         = en_q && (presc_cnt == '0);
  assign unused_wdata = ^writedata;

  // Writable configuration and target registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_q       <= 1'b0;
      prescale_q <= '0;
      step_q     <= '0;
      for (int c = 0; c < NUM_CH; c++) target_q[c] <= '0;
    end else if (wr_en) begin
      if (address == ADDR_W'(OFF_CTRL))     en_q       <= writedata[CTRL_EN_BIT];
      if (address == ADDR_W'(OFF_PRESCALE)) prescale_q <= writedata[PRESCALE_W-1:0];
      if (address == ADDR_W'(OFF_STEP))     step_q     <= writedata[CH_W-1:0];
      for (int c = 0; c < NUM_CH; c++) begin
        if (address == ADDR_W'(OFF_TARGET + c)) target_q[c] <= writedata[COL_W-1:0];
      end
    end
  end

  // Prescaler: held at PRESCALE while disabled, otherwise counts down and reloads on tick
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  presc_cnt <= '0;
    else if (!en_q || tick) presc_cnt <= prescale_q;
    else           presc_cnt <= presc_cnt - 1'b1;
  end

  // Sticky DONE bits; a new completion beats a simultaneous clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) done_q <= '0;
    else          done_q <= (done_q & ~done_w1c) | done_set;
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    led_fade_channel #(.CH_W(CH_W)) u_ch (
      .clk      (clk),
      .reset_n  (reset_n),
      .tick     (tick),
      .snap     (snap),
      .target   (target_q[c]),
      .step     (step_q),
      .current  (cur[c]),
      .busy     (busy[c]),
      .done_set (done_set[c])
    );
    assign out_port[c*COL_W +: COL_W] = cur[c];
  end

`ifdef LED_FADER_IRQ_EN
  logic irq_q;

  // Interrupt mask lives in CTRL alongside EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) irq_mask <= '0;
    else if (wr_en && (address == ADDR_W'(OFF_CTRL)))
      irq_mask <= writedata[CTRL_IRQ_MASK_LSB +: NUM_CH];
  end

  // Registered interrupt: any unmasked DONE bit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) irq_q <= 1'b0;
    else          irq_q <= |(done_q & irq_mask);
  end

  assign irq = irq_q;
`else
  assign irq_mask = '0;
  assign irq      = 1'b0;
`endif

  // Combinational read mux; unmapped words and unused bits read 0
  always_comb begin
    readdata = '0;
    if (address == ADDR_W'(OFF_CTRL)) begin
      readdata[CTRL_EN_BIT]                    = en_q;
      readdata[CTRL_IRQ_MASK_LSB +: NUM_CH]    = irq_mask;
    end
    if (address == ADDR_W'(OFF_STATUS)) begin
      readdata[STATUS_BUSY_LSB +: NUM_CH]      = busy;
      readdata[STATUS_DONE_LSB +: NUM_CH]      = done_q;
    end
    if (address == ADDR_W'(OFF_PRESCALE)) readdata[PRESCALE_W-1:0] = prescale_q;
    if (address == ADDR_W'(OFF_STEP))     readdata[CH_W-1:0]       = step_q;
    for (int c = 0; c < NUM_CH; c++) begin
      if (address == ADDR_W'(OFF_TARGET + c))             readdata[COL_W-1:0] = target_q[c];
      if (address == ADDR_W'(current_offset(NUM_CH, c))) readdata[COL_W-1:0] = cur[c];
    end
  end

endmodule
